// File: rtl/chram_write_arbiter.sv
// Three-requester write arbiter for the character-RAM write port.
// Round-robin single-word grants, locked bursts with a stall timeout, registered write port.
module chram_write_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BLANK_ONLY = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  blank,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_last,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  output logic                  wr_ena,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  abort
);

  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [7:0]        stall_q, stall_d;
  logic              wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;

  logic              gate;
  logic [1:0]        p1, p2, win_idx, grant_idx;
  logic              win_found, grant_en, xfer, sel_last, owner_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [1:0] next_idx(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  assign gate = (BLANK_ONLY == 0) || blank;

  // Round-robin scan starting at ptr
  always_comb begin
    p1        = next_idx(ptr_q);
    p2        = next_idx(p1);
    win_found = 1'b1;
    win_idx   = ptr_q;
    if (bit_at(req_valid, ptr_q))   win_idx = ptr_q;
    else if (bit_at(req_valid, p1)) win_idx = p1;
    else if (bit_at(req_valid, p2)) win_idx = p2;
    else                            win_found = 1'b0;
  end

  // Grant selection and payload mux
  always_comb begin
    owner_valid = bit_at(req_valid, owner_q);
    if (state_q == BURST) begin
      grant_idx = owner_q;
      grant_en  = gate && owner_valid;
    end else begin
      grant_idx = win_idx;
      grant_en  = gate && win_found;
    end
    xfer      = grant_en && !reset;
    req_ready = xfer ? 3'(3'b001 << grant_idx) : 3'b000;
    sel_last  = bit_at(req_last, grant_idx);
    case (grant_idx)
      2'd0: begin
        sel_addr = req_addr[0 +: ADDR_W];
        sel_data = req_data[0 +: DATA_W];
      end
      2'd1: begin
        sel_addr = req_addr[ADDR_W +: ADDR_W];
        sel_data = req_data[DATA_W +: DATA_W];
      end
      default: begin
        sel_addr = req_addr[2*ADDR_W +: ADDR_W];
        sel_data = req_data[2*DATA_W +: DATA_W];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    stall_d   = stall_q;
    wr_ena_d  = xfer;
    wr_addr_d = xfer ? sel_addr : wr_addr_q;
    wr_data_d = xfer ? sel_data : wr_data_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            ptr_d = next_idx(grant_idx);
          end else begin
            state_d = BURST;
            owner_d = grant_idx;
            stall_d = 8'd0;
          end
        end
      end
      default: begin
        if (xfer) begin
          stall_d = 8'd0;
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
          end
        end else if (gate && !owner_valid) begin
          // Owner stalled with the window open: count towards the timeout
          if (stall_q >= STALL_LIMIT) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
            stall_d = 8'd0;
            abort_d = 1'b1;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end
    endcase
    busy_d = (state_d == BURST);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      stall_q   <= 8'd0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      stall_q   <= stall_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_chram_write_arbiter.sv
// Bench for chram_write_arbiter: two parameterisations driven in lockstep,
// directed scenarios plus random traffic against a transaction-level model.
module tb_chram_write_arbiter;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        blank;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [32:0] req_addr;
  logic [23:0] req_data;

  logic [2:0]  rdy_a, rdy_b;
  logic        wena_a, wena_b, busy_a, busy_b, abort_a, abort_b;
  logic [10:0] waddr_a, waddr_b;
  logic [7:0]  wdata_a, wdata_b;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  chram_write_arbiter #(.ADDR_W(11), .DATA_W(8), .BLANK_ONLY(0), .TIMEOUT(4)) u_dut_a (
    .i_clk(i_clk), .reset(reset), .blank(blank), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(rdy_a), .wr_ena(wena_a),
    .wr_addr(waddr_a), .wr_data(wdata_a), .busy(busy_a), .abort(abort_a));

  chram_write_arbiter #(.ADDR_W(11), .DATA_W(8), .BLANK_ONLY(1), .TIMEOUT(6)) u_dut_b (
    .i_clk(i_clk), .reset(reset), .blank(blank), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(rdy_b), .wr_ena(wena_b),
    .wr_addr(waddr_b), .wr_data(wdata_b), .busy(busy_b), .abort(abort_b));

  // Reference model: one entry per instance
  int          blank_only_p [2] = '{0, 1};
  int          timeout_p    [2] = '{4, 6};
  int          m_burst [2];
  int          m_owner [2];
  int          m_ptr   [2];
  int          m_stall [2];
  logic [2:0]  e_rdy   [2];
  logic        e_ena   [2];
  logic [10:0] e_addr  [2];
  logic [7:0]  e_data  [2];
  logic        e_busy  [2];
  logic        e_abort [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_burst[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_stall[i] = 0;
      e_rdy[i] = 3'b000; e_ena[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
      e_busy[i] = 1'b0; e_abort[i] = 1'b0;
    end
  endtask

  // Decide this cycle's grant from the current inputs, then advance the model by one edge
  task automatic model_step(input int i);
    int  g;
    bit  gate;
    gate = (blank_only_p[i] == 0) || blank;
    g = -1;
    if (gate) begin
      if (m_burst[i] == 0) begin
        for (int k = 0; k < 3; k++)
          if (g < 0 && req_valid[(m_ptr[i] + k) % 3]) g = (m_ptr[i] + k) % 3;
      end else if (req_valid[m_owner[i]]) begin
        g = m_owner[i];
      end
    end
    e_abort[i] = 1'b0;
    if (g >= 0) begin
      e_rdy[i]  = 3'(1 << g);
      e_ena[i]  = 1'b1;
      e_addr[i] = req_addr[g*11 +: 11];
      e_data[i] = req_data[g*8 +: 8];
      if (m_burst[i] == 0) begin
        if (req_last[g]) m_ptr[i] = (g + 1) % 3;
        else begin m_burst[i] = 1; m_owner[i] = g; m_stall[i] = 0; end
      end else begin
        m_stall[i] = 0;
        if (req_last[g]) begin m_burst[i] = 0; m_ptr[i] = (m_owner[i] + 1) % 3; end
      end
    end else begin
      e_rdy[i] = 3'b000;
      e_ena[i] = 1'b0;
      if (m_burst[i] != 0 && gate && !req_valid[m_owner[i]]) begin
        m_stall[i]++;
        if (m_stall[i] == timeout_p[i]) begin
          m_burst[i] = 0; m_ptr[i] = (m_owner[i] + 1) % 3; m_stall[i] = 0;
          e_abort[i] = 1'b1;
        end
      end
    end
    e_busy[i] = (m_burst[i] != 0);
  endtask

  task automatic check_outputs();
    chk("a_wr_ena", 32'(wena_a), 32'(e_ena[0]));
    chk("a_wr_addr", 32'(waddr_a), 32'(e_addr[0]));
    chk("a_wr_data", 32'(wdata_a), 32'(e_data[0]));
    chk("a_busy", 32'(busy_a), 32'(e_busy[0]));
    chk("a_abort", 32'(abort_a), 32'(e_abort[0]));
    chk("b_wr_ena", 32'(wena_b), 32'(e_ena[1]));
    chk("b_wr_addr", 32'(waddr_b), 32'(e_addr[1]));
    chk("b_wr_data", 32'(wdata_b), 32'(e_data[1]));
    chk("b_busy", 32'(busy_b), 32'(e_busy[1]));
    chk("b_abort", 32'(abort_b), 32'(e_abort[1]));
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    chk("a_ready", 32'(rdy_a), 32'(e_rdy[0]));
    chk("b_ready", 32'(rdy_b), 32'(e_rdy[1]));
    @(posedge i_clk);
    #1;
    check_outputs();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    req_last  = 3'b111;
    #1;
    model_reset();
    check_outputs();
    chk("a_ready_rst", 32'(rdy_a), 32'd0);
    chk("b_ready_rst", 32'(rdy_b), 32'd0);
    @(posedge i_clk);
    #1;
    check_outputs();
    @(negedge i_clk);
    reset = 1'b0;
    req_valid = 3'b000;
    req_last  = 3'b000;
  endtask

  task automatic set_req(input int i, input logic [10:0] a, input logic [7:0] d);
    req_addr[i*11 +: 11] = a;
    req_data[i*8 +: 8]   = d;
  endtask

  initial begin
    reset = 1'b0; blank = 1'b1; req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // All three valid single-word requests rotate 0,1,2,0
    set_req(0, 11'd10, 8'hA0); set_req(1, 11'd20, 8'hB1); set_req(2, 11'd30, 8'hC2);
    req_valid = 3'b111; req_last = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", 32'(rdy_a), 32'(1 << (k % 3)));
      tick();
    end

    // Req1 16-word burst while req0/req2 stay valid
    do_reset();
    set_req(0, 11'd5, 8'h55); req_valid = 3'b001; req_last = 3'b111;
    tick();
    req_valid = 3'b111; req_last = 3'b101;
    for (int k = 0; k < 16; k++) begin
      set_req(1, 11'(136 + k), 8'(k));
      if (k == 15) req_last = 3'b111;
      #1 chk("burst_owner", 32'(rdy_a), 32'b010);
      tick();
      if (k < 15) chk("burst_busy", 32'(busy_a), 32'd1);
    end
    chk("burst_end_addr", 32'(waddr_a), 32'd151);
    #1 chk("after_burst_grant", 32'(rdy_a), 32'b100);
    tick();

    // Blank gating on the BLANK_ONLY instance
    do_reset();
    blank = 1'b0; set_req(0, 11'd77, 8'h3C); req_valid = 3'b001; req_last = 3'b001;
    #1 chk("blank_gate_ready", 32'(rdy_b), 32'd0);
    tick();
    chk("blank_gate_wena", 32'(wena_b), 32'd0);
    blank = 1'b1;
    tick();
    chk("blank_open_addr", 32'(waddr_b), 32'd77);
    req_valid = 3'b000;
    tick();

    // Stall timeout on req2 (TIMEOUT=4 instance)
    do_reset();
    set_req(2, 11'd200, 8'h22); req_valid = 3'b100; req_last = 3'b000;
    tick();
    req_valid = 3'b000;
    for (int k = 0; k < 4; k++) tick();
    chk("timeout_abort", 32'(abort_a), 32'd1);
    chk("timeout_busy", 32'(busy_a), 32'd0);
    req_valid = 3'b111; req_last = 3'b111;
    #1 chk("timeout_next_grant", 32'(rdy_a), 32'b001);
    tick();

    // Reset in the middle of a req0 burst, then req1 alone
    do_reset();
    req_valid = 3'b001; req_last = 3'b000;
    for (int k = 0; k < 3; k++) begin set_req(0, 11'(400 + k), 8'(k)); tick(); end
    do_reset();
    set_req(1, 11'd500, 8'h51); req_valid = 3'b010; req_last = 3'b010;
    tick();
    chk("post_reset_addr", 32'(waddr_a), 32'd500);

    // Single word from req0, then ptr should start the scan at req1
    do_reset();
    set_req(0, 11'd331, 8'h2A); req_valid = 3'b001; req_last = 3'b001;
    tick();
    chk("single_wena", 32'(wena_a), 32'd1);
    chk("single_addr", 32'(waddr_a), 32'd331);
    chk("single_data", 32'(wdata_a), 32'h2A);
    req_valid = 3'b111; req_last = 3'b111;
    #1 chk("single_ptr", 32'(rdy_a), 32'b010);
    tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      blank     = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom);
      req_last  = 3'($urandom) & 3'($urandom);
      req_addr  = 33'({$urandom, $urandom});
      req_data  = 24'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
